// File: rtl/data_ram.sv
// Byte-lane-writable word RAM with fixed read latency and ready/valid load handshake.
// Optional out-of-range detection and addrError output when RAM_BOUNDS_CHECK_EN is defined.
module data_ram #(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 2,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] addressIn,
   input  logic [DATA_WIDTH-1:0] dataWriteIn,
   input  logic [3:0]            byteSelect,
   input  logic                  storeIn,
   input  logic                  loadIn,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] dataReadOut,
`ifdef RAM_BOUNDS_CHECK_EN
   output logic                  addrError,
`endif
   output logic                  dataValid
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic {IDLE, READ_WAIT} state_t;

   state_t          state, state_next;
   logic [1:0]      cnt, cnt_next;
   logic [AW-1:0]   idx, lat_idx, lat_idx_next, finish_idx;
   logic            do_write, finish;
   logic            oob, finish_oob;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   assign idx   = addressIn[AW+1:2];
   assign ready = (state == IDLE);

   // Byte offset is meaningless for whole-word access; upper bits only matter for bounds check.
   logic unused_addr;
   assign unused_addr = ^{addressIn[1:0], addressIn[DATA_WIDTH-1:AW+2]};

`ifdef RAM_BOUNDS_CHECK_EN
   logic lat_oob;
   assign oob        = (addressIn[DATA_WIDTH-1:AW+2] != '0);
   assign finish_oob = (state == IDLE) ? oob : lat_oob;

   always_ff @(posedge clk) begin
      if (reset) begin
         lat_oob   <= 1'b0;
         addrError <= 1'b0;
      end else begin
         if (state == IDLE && loadIn && !storeIn) lat_oob <= oob;
         addrError <= (do_write && oob) || (finish && finish_oob);
      end
   end
`else
   assign oob        = 1'b0;
   assign finish_oob = 1'b0;
`endif

   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      lat_idx_next = lat_idx;
      do_write     = 1'b0;
      finish       = 1'b0;
      finish_idx   = lat_idx;
      case (state)
         IDLE: begin
            if (storeIn) begin
               do_write = 1'b1;
            end else if (loadIn) begin
               if (READ_LATENCY == 1) begin
                  finish     = 1'b1;
                  finish_idx = idx;
               end else begin
                  state_next   = READ_WAIT;
                  cnt_next     = 2'(READ_LATENCY - 1);
                  lat_idx_next = idx;
               end
            end
         end
         READ_WAIT: begin
            cnt_next = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
            if (cnt <= 2'd1) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= 2'd0;
         lat_idx     <= '0;
         dataValid   <= 1'b0;
         dataReadOut <= '0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         lat_idx   <= lat_idx_next;
         dataValid <= finish;
         if (finish) dataReadOut <= finish_oob ? '0 : mem[finish_idx];
      end
   end

   // Memory contents are deliberately not reset; reset only blocks a concurrent write.
   always_ff @(posedge clk) begin
      if (!reset && do_write && !oob) begin
         for (int n = 0; n < 4; n++) begin
            if (byteSelect[n]) mem[idx][8*n +: 8] <= dataWriteIn[8*n +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: default-latency instance plus latency-1 and latency-4 instances.
module tb_data_ram;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        store, load, ready, valid, aerr;

   logic [31:0] l_addr [2];
   logic [31:0] l_wdata [2];
   logic [31:0] l_rdata [2];
   logic [3:0]  l_be [2];
   logic        l_store [2];
   logic        l_load [2];
   logic        l_ready [2];
   logic        l_valid [2];
   logic        l_aerr [2];

   data_ram dut (
      .clk(clk), .reset(reset), .addressIn(addr), .dataWriteIn(wdata), .byteSelect(be),
      .storeIn(store), .loadIn(load), .ready(ready), .dataReadOut(rdata),
`ifdef RAM_BOUNDS_CHECK_EN
      .addrError(aerr),
`endif
      .dataValid(valid)
   );

   data_ram #(.DEPTH_WORDS(16), .READ_LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .addressIn(l_addr[0]), .dataWriteIn(l_wdata[0]), .byteSelect(l_be[0]),
      .storeIn(l_store[0]), .loadIn(l_load[0]), .ready(l_ready[0]), .dataReadOut(l_rdata[0]),
`ifdef RAM_BOUNDS_CHECK_EN
      .addrError(l_aerr[0]),
`endif
      .dataValid(l_valid[0])
   );

   data_ram #(.DEPTH_WORDS(16), .READ_LATENCY(4)) dut_l4 (
      .clk(clk), .reset(reset), .addressIn(l_addr[1]), .dataWriteIn(l_wdata[1]), .byteSelect(l_be[1]),
      .storeIn(l_store[1]), .loadIn(l_load[1]), .ready(l_ready[1]), .dataReadOut(l_rdata[1]),
`ifdef RAM_BOUNDS_CHECK_EN
      .addrError(l_aerr[1]),
`endif
      .dataValid(l_valid[1])
   );

`ifndef RAM_BOUNDS_CHECK_EN
   assign aerr = 1'b0;
   assign l_aerr[0] = 1'b0;
   assign l_aerr[1] = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      addr = a; wdata = d; be = b; store = 1'b1;
      tick();
      store = 1'b0; be = 4'h0;
   endtask

   // Returns data seen on the dataValid cycle and cycles from acceptance (99 on timeout).
   task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int lat, output logic e);
      addr = a; load = 1'b1;
      tick();
      load = 1'b0;
      lat = 1;
      while (!valid && lat < 10) begin
         tick();
         lat++;
      end
      d = rdata;
      e = aerr;
      if (!valid) lat = 99;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
      checks++; if (aerr !== 1'b0) begin errors++; $display("FAIL reset_aerr: got %b expected 0", aerr); end
      checks++; if (l_ready[1] !== 1'b1) begin errors++; $display("FAIL reset_ready_l4: got %b expected 1", l_ready[1]); end
   endtask

   task automatic test_full_word();
      do_store(32'h10, 32'hDEADBEEF, 4'hF);
      addr = 32'h10; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL fw_busy: got ready %b expected 0", ready); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fw_early_valid: got %b expected 0", valid); end
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL fw_valid: got %b expected 1", valid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_data: got %h expected deadbeef", rdata); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fw_ready_back: got %b expected 1", ready); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fw_pulse: got %b expected 0", valid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fw_hold: got %h expected deadbeef", rdata); end
   endtask

   task automatic test_byte_merge();
      logic [31:0] d; int lat; logic e;
      do_store(32'h20, 32'h11223344, 4'hF);
      do_store(32'h20, 32'h0000AA00, 4'b0010);
      do_load(32'h20, d, lat, e);
      checks++; if (d !== 32'h1122AA44) begin errors++; $display("FAIL merge_lane1: got %h expected 1122aa44", d); end
      do_store(32'h20, 32'h55660000, 4'b1100);
      do_load(32'h23, d, lat, e);
      checks++; if (d !== 32'h5566AA44) begin errors++; $display("FAIL merge_upper: got %h expected 5566aa44", d); end
      do_store(32'h20, 32'hFFFFFFFF, 4'b0000);
      do_load(32'h20, d, lat, e);
      checks++; if (d !== 32'h5566AA44) begin errors++; $display("FAIL merge_noop: got %h expected 5566aa44", d); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL merge_latency: got %0d expected 2", lat); end
   endtask

   task automatic test_collision_busy();
      logic [31:0] d; int lat; logic e; int pulses;
      addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF; store = 1'b1; load = 1'b1;
      tick();
      store = 1'b0; load = 1'b0; be = 4'h0;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL coll_ready: got %b expected 1", ready); end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         if (valid) pulses++;
         tick();
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL coll_no_valid: got %0d pulses expected 0", pulses); end
      do_load(32'h30, d, lat, e);
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL coll_write: got %h expected cafef00d", d); end
      addr = 32'h30; load = 1'b1;
      tick();
      wdata = 32'h12345678; be = 4'hF; store = 1'b1;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", ready); end
      tick();
      store = 1'b0; load = 1'b0; be = 4'h0;
      tick(); tick();
      do_load(32'h30, d, lat, e);
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL busy_store_ignored: got %h expected cafef00d", d); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d; int lat; logic e;
      addr = 32'h10; load = 1'b1;
      tick();
      load = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_read_valid: got %b expected 0", valid); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_read_ready: got %b expected 1", ready); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_read_data: got %h expected 0", rdata); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_read_late: got %b expected 0", valid); end
      reset = 1'b1; addr = 32'h30; wdata = 32'h0; be = 4'hF; store = 1'b1;
      tick();
      reset = 1'b0; store = 1'b0; be = 4'h0;
      do_load(32'h30, d, lat, e);
      checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_store_blocked: got %h expected cafef00d", d); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; int lat; logic e;
      do_store(32'h0, 32'hA5A5A5A5, 4'hF);
      addr = 32'h1000; wdata = 32'h01020304; be = 4'hF; store = 1'b1;
      tick();
      store = 1'b0; be = 4'h0;
`ifdef RAM_BOUNDS_CHECK_EN
      checks++; if (aerr !== 1'b1) begin errors++; $display("FAIL oob_store_err: got %b expected 1", aerr); end
      tick();
      checks++; if (aerr !== 1'b0) begin errors++; $display("FAIL oob_store_pulse: got %b expected 0", aerr); end
      do_load(32'h0, d, lat, e);
      checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL oob_word0: got %h expected a5a5a5a5", d); end
      do_load(32'h1000, d, lat, e);
      checks++; if (d !== 32'h0 || e !== 1'b1 || lat !== 2) begin errors++; $display("FAIL oob_load: got %h err %b lat %0d expected 0 1 2", d, e, lat); end
`else
      checks++; if (aerr !== 1'b0) begin errors++; $display("FAIL wrap_no_err: got %b expected 0", aerr); end
      do_load(32'h0, d, lat, e);
      checks++; if (d !== 32'h01020304) begin errors++; $display("FAIL wrap_word0: got %h expected 01020304", d); end
`endif
   endtask

   task automatic test_latency();
      int lat;
      for (int i = 0; i < 2; i++) begin
         l_addr[i] = 32'h4; l_wdata[i] = 32'h11111111; l_be[i] = 4'hF; l_store[i] = 1'b1;
         tick();
         l_addr[i] = 32'h8; l_wdata[i] = 32'h22222222;
         tick();
         l_store[i] = 1'b0; l_be[i] = 4'h0;
      end
      // Latency 1: load held high for two cycles streams A then B.
      l_addr[0] = 32'h4; l_load[0] = 1'b1;
      tick();
      checks++; if (l_valid[0] !== 1'b1 || l_rdata[0] !== 32'h11111111) begin errors++; $display("FAIL l1_first: got v %b d %h expected 1 11111111", l_valid[0], l_rdata[0]); end
      l_addr[0] = 32'h8;
      tick();
      l_load[0] = 1'b0;
      checks++; if (l_valid[0] !== 1'b1 || l_rdata[0] !== 32'h22222222) begin errors++; $display("FAIL l1_second: got v %b d %h expected 1 22222222", l_valid[0], l_rdata[0]); end
      tick();
      checks++; if (l_valid[0] !== 1'b0) begin errors++; $display("FAIL l1_idle: got %b expected 0", l_valid[0]); end
      // Latency 4: load stays high while busy; only the request seen in IDLE is taken.
      l_addr[1] = 32'h4; l_load[1] = 1'b1;
      tick();
      l_addr[1] = 32'h8;
      checks++; if (l_ready[1] !== 1'b0) begin errors++; $display("FAIL l4_busy: got %b expected 0", l_ready[1]); end
      lat = 1;
      while (!l_valid[1] && lat < 10) begin tick(); lat++; end
      checks++; if (lat !== 4 || l_rdata[1] !== 32'h11111111) begin errors++; $display("FAIL l4_first: got lat %0d d %h expected 4 11111111", lat, l_rdata[1]); end
      tick();
      l_load[1] = 1'b0;
      lat = 1;
      while (!l_valid[1] && lat < 10) begin tick(); lat++; end
      checks++; if (lat !== 4 || l_rdata[1] !== 32'h22222222) begin errors++; $display("FAIL l4_second: got lat %0d d %h expected 4 22222222", lat, l_rdata[1]); end
      tick();
      checks++; if (l_valid[1] !== 1'b0) begin errors++; $display("FAIL l4_idle: got %b expected 0", l_valid[1]); end
   endtask

   initial begin
      reset = 1'b0; addr = '0; wdata = '0; be = '0; store = 1'b0; load = 1'b0;
      for (int i = 0; i < 2; i++) begin
         l_addr[i] = '0; l_wdata[i] = '0; l_be[i] = '0; l_store[i] = 1'b0; l_load[i] = 1'b0;
      end
      test_reset();
      test_full_word();
      test_byte_merge();
      test_collision_busy();
      test_reset_mid_read();
      test_out_of_range();
      test_latency();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_ram.md
# data_ram

Word-organised, byte-lane-writable data RAM that acts as the responder on the RAM side of `memoryController`. It accepts the lane-aligned write data, byte-select mask, byte address and store/load strobes that the controller drives. It returns full 32-bit words after a fixed, parameterised read latency. A ready/valid handshake lets the CPU stall while a load is in flight.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `READ_LATENCY`, 2: cycles from load acceptance to `dataValid`; legal range 1–4.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `addressIn` input `DATA_WIDTH`: byte address. Word index = `addressIn[log2(DEPTH_WORDS)+1:2]`; bits [1:0] are ignored.
- `dataWriteIn` input `DATA_WIDTH`: lane-aligned write data (byte n on bits [8n+7:8n]).
- `byteSelect` input 4: per-lane write enable; bit n enables byte n.
- `storeIn` input 1: store request.
- `loadIn` input 1: load request.
- `ready` output 1: block can accept a request this cycle.
- `dataReadOut` output `DATA_WIDTH`: full word read, registered.
- `dataValid` output 1: one-cycle pulse; `dataReadOut` is valid.
- `addrError` output 1: out-of-range access pulse. Present only with `RAM_BOUNDS_CHECK_EN`.

## Operation
- FSM states are IDLE and READ_WAIT. `ready` = (state == IDLE).
- In IDLE with `storeIn`:
  - Write `dataWriteIn` byte n to the addressed word for each set `byteSelect[n]`, at that edge.
  - Unselected bytes are unchanged.
  - State stays IDLE.
  - `byteSelect` = 0 is accepted as a no-op.
- In IDLE with `loadIn` and not `storeIn`:
  - Latch the word index.
  - Load the down-counter with `READ_LATENCY`-1.
  - Go to READ_WAIT.
  - If `READ_LATENCY`=1, skip READ_WAIT: `dataReadOut`/`dataValid` update at the next edge and state stays IDLE.
- In READ_WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, register the latched word into `dataReadOut`, pulse `dataValid` for one cycle, and return to IDLE.
- Simultaneous `storeIn` and `loadIn` in IDLE: the store executes and the load is dropped (no `dataValid`).
- Requests while `ready`=0 are ignored entirely: no write and no queued load.
- `byteSelect` is ignored for loads. The full word is always returned; lane extraction and sign extension belong to the controller.
- `dataReadOut` holds its last value between `dataValid` pulses.
- Memory contents are not reset and are X after power-up in simulation.

## Timing
- Reset values: state IDLE, `ready`=1, `dataValid`=0, `dataReadOut`=0, `addrError`=0, counter=0.
- Store latency: written at the acceptance edge. A load accepted on the next cycle returns the new data.
- Load latency: load accepted at edge E; `dataValid`=1 in the cycle following edge E+`READ_LATENCY`-1.
- `ready` is low for `READ_LATENCY`-1 cycles after a load is accepted. Back-to-back loads therefore sustain one load per `READ_LATENCY` cycles.
- `reset` during READ_WAIT abandons the read: no `dataValid` pulse, IDLE on the next cycle.
- `reset` concurrent with `storeIn`: no write occurs.
- Address wrap: without the bounds check, word index bits above log2(`DEPTH_WORDS`) are discarded, so access is modulo depth.

## Configuration
- `RAM_BOUNDS_CHECK_EN` defined:
  - Any request with `addressIn` ≥ 4·`DEPTH_WORDS` is accepted but has no memory effect.
  - A store makes `addrError` pulse for one cycle, at the acceptance edge.
  - A load completes with the normal latency, returns `dataReadOut`=0, and pulses `addrError` together with `dataValid`.
- Not defined:
  - The `addrError` port and its logic are absent.
  - Addresses wrap modulo depth.

## Test plan
- **Full-word store/load:** store 0xDEADBEEF at 0x10 with `byteSelect`=4'b1111, then load 0x10 → `dataValid` after 2 cycles (default latency) with `dataReadOut`=0xDEADBEEF, and `ready` low for 1 cycle.
- **Byte-lane merge:** preload 0x11223344 at 0x20, then store 0x0000AA00 with `byteSelect`=4'b0010 → load returns 0x1122AA44. A store with `byteSelect`=4'b1100 and data 0x55660000 then gives 0x5566AA44.
- **Collision and busy:** assert `storeIn` and `loadIn` together → write occurs and no `dataValid` follows. A store issued while `ready`=0 during a load → memory is unchanged.
- **Reset mid-read:** load accepted, then `reset` asserted the next cycle → no `dataValid` pulse, and `ready`=1 and `dataReadOut`=0 after reset.
- **Latency sweep:** run with `READ_LATENCY`=1 and =4 → `dataValid` arrives exactly 1 and 4 cycles after acceptance, and back-to-back loads return in order.
- **Out of range:** with `RAM_BOUNDS_CHECK_EN` and `DEPTH_WORDS`=1024, store to 0x1000 → `addrError` pulse, and word 0 is unchanged. Without the macro, the same store overwrites word 0.
